// File: rtl/throw_scheduler.sv
// -----------------------------------------------------------------------------
// throw_scheduler
//
// Arbitrates throw requests between a local and a remote player and sequences
// each throw through launch, flight and a post-throw lockout.
//
//   IDLE     -> waits for a rising request edge from the player holding the turn
//   LAUNCH   -> one cycle, start_throw high, thrower's launch count bumped
//   FLIGHT   -> waits for end_throw or the flight timeout
//   COOLDOWN -> fixed lockout, then back to IDLE
//
// Parameters
//   COOLDOWN_CYCLES : lockout length in clk60MHz cycles
//   TIMEOUT_CYCLES  : flight window in cycles, counted from the LAUNCH cycle
//
// Ports
//   clk60MHz      : system clock
//   rst           : synchronous, active-high reset
//   req_local     : local player throw request (level, edge-detected here)
//   req_remote    : remote player throw request (level, edge-detected here)
//   end_throw     : trajectory finished; honoured only during FLIGHT
//   start_throw   : one-cycle launch pulse to the trajectory engine
//   owner         : thrower of the current or last throw (0 local, 1 remote)
//   turn          : player allowed to throw next (0 local, 1 remote)
//   busy          : high whenever the scheduler is not IDLE
//   reject        : one-cycle pulse when a request edge is refused
//   timeout       : one-cycle pulse when a flight is force-terminated
//   throws_local  : saturating count of local launches
//   throws_remote : saturating count of remote launches
//
// All outputs are registered and change only on the rising clock edge.
// -----------------------------------------------------------------------------
module throw_scheduler #(
    parameter int unsigned COOLDOWN_CYCLES = 6_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 180_000_000
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic       req_local,
    input  logic       req_remote,
    input  logic       end_throw,
    output logic       start_throw,
    output logic       owner,
    output logic       turn,
    output logic       busy,
    output logic       reject,
    output logic       timeout,
    output logic [7:0] throws_local,
    output logic [7:0] throws_remote
);

    localparam int unsigned CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);
    // The registered timeout pulse must land TIMEOUT_CYCLES after LAUNCH, so
    // expiry is taken on the cycle where the flight counter is about to step
    // onto TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LAUNCH   = 2'd1,
        S_FLIGHT   = 2'd2,
        S_COOLDOWN = 2'd3
    } state_e;

    state_e            state_q;
    logic              req_local_q;
    logic              req_remote_q;
    logic [TO_W-1:0]   flight_cnt_q;
    logic [CD_W-1:0]   cd_cnt_q;
    logic              start_q;
    logic              owner_q;
    logic              turn_q;
    logic              busy_q;
    logic              reject_q;
    logic              timeout_q;
    logic [7:0]        throws_local_q;
    logic [7:0]        throws_remote_q;

    logic edge_local;
    logic edge_remote;
    logic edge_turn;
    logic edge_other;

    assign edge_local  = req_local  & ~req_local_q;
    assign edge_remote = req_remote & ~req_remote_q;
    assign edge_turn   = turn_q ? edge_remote : edge_local;
    assign edge_other  = turn_q ? edge_local  : edge_remote;

    // NOTE: every register below is assigned with <= so all updates in this
    // block see the values from before the clock edge, as real flops do.
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state_q         <= S_IDLE;
            req_local_q     <= 1'b0;
            req_remote_q    <= 1'b0;
            flight_cnt_q    <= '0;
            cd_cnt_q        <= '0;
            start_q         <= 1'b0;
            owner_q         <= 1'b0;
            turn_q          <= 1'b0;
            busy_q          <= 1'b0;
            reject_q        <= 1'b0;
            timeout_q       <= 1'b0;
            throws_local_q  <= '0;
            throws_remote_q <= '0;
        end else begin
            req_local_q  <= req_local;
            req_remote_q <= req_remote;
            start_q      <= 1'b0;
            timeout_q    <= 1'b0;
            // Outside IDLE every request edge is refused; IDLE overrides below.
            reject_q     <= edge_local | edge_remote;

            case (state_q)
                S_IDLE: begin
                    reject_q <= edge_other;
                    if (edge_turn) begin
                        state_q <= S_LAUNCH;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        owner_q <= turn_q;
                        // Count lands together with the LAUNCH cycle.
                        if (turn_q) begin
                            if (throws_remote_q != 8'hFF) throws_remote_q <= throws_remote_q + 8'd1;
                        end else begin
                            if (throws_local_q != 8'hFF) throws_local_q <= throws_local_q + 8'd1;
                        end
                    end
                end

                S_LAUNCH: begin
                    state_q      <= S_FLIGHT;
                    flight_cnt_q <= '0;
                end

                S_FLIGHT: begin
                    if (end_throw || flight_cnt_q == TO_LAST) begin
                        state_q   <= S_COOLDOWN;
                        cd_cnt_q  <= '0;
                        turn_q    <= ~turn_q;
                        // A real end of flight wins over a coincident expiry.
                        timeout_q <= ~end_throw;
                    end else begin
                        flight_cnt_q <= flight_cnt_q + 1'b1;
                    end
                end

                S_COOLDOWN: begin
                    if (cd_cnt_q == CD_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cd_cnt_q <= cd_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign start_throw   = start_q;
    assign owner         = owner_q;
    assign turn          = turn_q;
    assign busy          = busy_q;
    assign reject        = reject_q;
    assign timeout       = timeout_q;
    assign throws_local  = throws_local_q;
    assign throws_remote = throws_remote_q;

endmodule

// File: tb/tb_throw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_throw_scheduler
//
// Self-checking bench for throw_scheduler with COOLDOWN_CYCLES=4 and
// TIMEOUT_CYCLES=20. A reference model tracks each throw by the cycle numbers
// of its launch and its cooldown start, and predicts every output one cycle
// ahead. Directed scenarios exercise the documented corner cases; a random
// phase follows.
// -----------------------------------------------------------------------------
module tb_throw_scheduler;

    localparam int COOL = 4;
    localparam int TOUT = 20;

    logic       clk60MHz = 1'b0;
    logic       rst = 1'b1;
    logic       req_local = 1'b0;
    logic       req_remote = 1'b0;
    logic       end_throw = 1'b0;
    logic       start_throw;
    logic       owner;
    logic       turn;
    logic       busy;
    logic       reject;
    logic       timeout;
    logic [7:0] throws_local;
    logic [7:0] throws_remote;

    throw_scheduler #(
        .COOLDOWN_CYCLES(COOL),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk60MHz     (clk60MHz),
        .rst          (rst),
        .req_local    (req_local),
        .req_remote   (req_remote),
        .end_throw    (end_throw),
        .start_throw  (start_throw),
        .owner        (owner),
        .turn         (turn),
        .busy         (busy),
        .reject       (reject),
        .timeout      (timeout),
        .throws_local (throws_local),
        .throws_remote(throws_remote)
    );

    always #8 clk60MHz = ~clk60MHz;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: a throw is described by its launch cycle m_launch and
    // the first cooldown cycle m_cd (-1 while still in flight).
    int m_launch = -2000;
    int m_cd     = -1000;
    bit m_pl     = 1'b0;
    bit m_pr     = 1'b0;
    bit exp_start, exp_reject, exp_timeout, exp_owner, exp_turn, exp_busy;
    int exp_tl, exp_tr;

    function automatic bit flying(input int x);
        return (x > m_launch) && (m_cd == -1);
    endfunction

    function automatic bit cooling(input int x);
        return (m_cd >= 0) && (x >= m_cd) && (x < m_cd + COOL);
    endfunction

    // Drive inputs for the current cycle, predict the next cycle's outputs,
    // advance one clock and compare everything.
    task automatic step(input bit rl, input bit rr, input bit et, input bit rs);
        bit el, er, mine, other, idle;
        req_local  = rl;
        req_remote = rr;
        end_throw  = et;
        rst        = rs;

        exp_start   = 1'b0;
        exp_reject  = 1'b0;
        exp_timeout = 1'b0;
        if (rs) begin
            m_launch  = -2000;
            m_cd      = -1000;
            m_pl      = 1'b0;
            m_pr      = 1'b0;
            exp_owner = 1'b0;
            exp_turn  = 1'b0;
            exp_tl    = 0;
            exp_tr    = 0;
        end else begin
            el   = rl && !m_pl;
            er   = rr && !m_pr;
            m_pl = rl;
            m_pr = rr;
            idle = (cyc != m_launch) && !flying(cyc) && !cooling(cyc);
            if (idle) begin
                mine  = exp_turn ? er : el;
                other = exp_turn ? el : er;
                exp_reject = other;
                if (mine) begin
                    m_launch  = cyc + 1;
                    m_cd      = -1;
                    exp_start = 1'b1;
                    exp_owner = exp_turn;
                    if (exp_turn) exp_tr = (exp_tr < 255) ? exp_tr + 1 : 255;
                    else          exp_tl = (exp_tl < 255) ? exp_tl + 1 : 255;
                end
            end else begin
                exp_reject = el || er;
                if (flying(cyc)) begin
                    if (et) begin
                        m_cd     = cyc + 1;
                        exp_turn = !exp_turn;
                    end else if (cyc == m_launch + TOUT - 1) begin
                        m_cd        = cyc + 1;
                        exp_turn    = !exp_turn;
                        exp_timeout = 1'b1;
                    end
                end
            end
        end
        exp_busy = (cyc + 1 == m_launch) || flying(cyc + 1) || cooling(cyc + 1);

        @(posedge clk60MHz);
        #1;
        cyc++;
        check("start_throw",   32'(start_throw),   32'(exp_start));
        check("reject",        32'(reject),        32'(exp_reject));
        check("timeout",       32'(timeout),       32'(exp_timeout));
        check("owner",         32'(owner),         32'(exp_owner));
        check("turn",          32'(turn),          32'(exp_turn));
        check("busy",          32'(busy),          32'(exp_busy));
        check("throws_local",  32'(throws_local),  exp_tl);
        check("throws_remote", 32'(throws_remote), exp_tr);
    endtask

    initial begin
        int base;
        int rej_cnt;
        int start_cnt;
        bit rl, rr, et, rs;

        @(posedge clk60MHz);
        #1;
        cyc = 0;

        // Reset, then a local throw whose request rises at cycle 10.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_busy",  32'(busy),          0);
        check("rst_turn",  32'(turn),          0);
        check("rst_count", 32'(throws_local),  0);
        while (cyc < 10) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("c11_start", 32'(start_throw),  1);
        check("c11_owner", 32'(owner),        0);
        check("c11_busy",  32'(busy),         1);
        check("c11_count", 32'(throws_local), 1);
        step(1, 0, 0, 0);
        check("c12_start", 32'(start_throw),  0);
        while (cyc < 15) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check("c16_turn",  32'(turn), 1);
        while (cyc < 19) step(1, 0, 0, 0);
        check("c19_busy",  32'(busy), 1);
        step(1, 0, 0, 0);
        check("c20_busy",  32'(busy), 0);

        // Remote throw left to time out: pulse exactly TOUT cycles after LAUNCH.
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        base = cyc;
        check("rl_start", 32'(start_throw), 1);
        check("rl_owner", 32'(owner),       1);
        for (int k = 1; k <= TOUT; k++) begin
            step(0, 1, 0, 0);
            if (k < TOUT) check("to_early", 32'(timeout), 0);
        end
        check("to_pulse", 32'(timeout), 1);
        check("to_turn",  32'(turn),    0);
        for (int k = 0; k < COOL; k++) step(0, 1, 0, 0);
        check("to_idle",  32'(busy), 0);

        // Simultaneous edges with turn=0: local wins, single reject.
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        base = cyc;
        check("both_start",  32'(start_throw),   1);
        check("both_reject", 32'(reject),        1);
        check("both_owner",  32'(owner),         0);
        check("both_remote", 32'(throws_remote), 1);
        step(0, 0, 0, 0);
        check("both_rej1",   32'(reject), 0);

        // req_remote rises mid-flight and stays high; end_throw on expiry cycle.
        rej_cnt   = 0;
        start_cnt = 0;
        while (cyc < base + TOUT - 1) begin
            step(0, (cyc >= base + 3), 0, 0);
            rej_cnt   += int'(reject);
            start_cnt += int'(start_throw);
        end
        step(0, 1, 1, 0);
        check("et_wins_to", 32'(timeout), 0);
        check("et_turn",    32'(turn),    1);
        rej_cnt += int'(reject);
        for (int k = 0; k < COOL + 8; k++) begin
            step(0, 1, 0, 0);
            rej_cnt   += int'(reject);
            start_cnt += int'(start_throw);
        end
        check("held_rejects", rej_cnt,   1);
        check("held_nolaunch", start_cnt, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("fresh_start", 32'(start_throw), 1);
        check("fresh_owner", 32'(owner),       1);

        // Reset in the middle of a flight.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        check("mid_rst_start",  32'(start_throw),   0);
        check("mid_rst_busy",   32'(busy),          0);
        check("mid_rst_owner",  32'(owner),         0);
        check("mid_rst_remote", 32'(throws_remote), 0);
        check("mid_rst_to",     32'(timeout),       0);

        // Alternating accepted throws until both counters saturate.
        step(0, 0, 0, 1);
        for (int n = 0; n < 520; n++) begin
            if (exp_turn) step(0, 1, 0, 0);
            else          step(1, 0, 0, 0);
            step(0, 0, 0, 0);
            step(0, 0, 1, 0);
            for (int k = 0; k < COOL; k++) step(0, 0, 0, 0);
        end
        check("sat_local",  32'(throws_local),  255);
        check("sat_remote", 32'(throws_remote), 255);

        // Random traffic.
        rl = 1'b0;
        rr = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 7) == 0) rl = !rl;
            if ($urandom_range(0, 7) == 0) rr = !rr;
            et = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 499) == 0);
            step(rl, rr, et, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
